// File: rtl/mult_div_sequencer_if.sv
// Handshake and HI/LO bundle for mult_div_sequencer.
// Build option: MDU_DIVZERO_EN adds the div_zero flag.
//   start, op, a, b    : operation request (master -> slave)
//   hi_we, lo_we, wdata: MTHI/MTLO writes (master -> slave)
//   busy, done         : operation status (slave -> master)
//   hi, lo             : architectural HI/LO registers (slave -> master)
//   div_zero           : divide-by-zero flag in the done cycle (MDU_DIVZERO_EN only)
interface mult_div_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MDU_DIVZERO_EN
  logic             div_zero;

  modport master (output start, op, a, b, hi_we, lo_we, wdata,
                  input busy, done, hi, lo, div_zero);
  modport slave (input start, op, a, b, hi_we, lo_we, wdata,
                 output busy, done, hi, lo, div_zero);
`else
  modport master (output start, op, a, b, hi_we, lo_we, wdata,
                  input busy, done, hi, lo);
  modport slave (input start, op, a, b, hi_we, lo_we, wdata,
                 output busy, done, hi, lo);
`endif
endinterface

// File: rtl/mult_div_sequencer.sv
// Multi-cycle HI/LO unit: MULTU/MULT/DIVU/DIV at one bit per cycle on a shared
// add/subtract datapath, plus MTHI/MTLO writes into the HI/LO registers.
// Build option: MDU_DIVZERO_EN makes a divide by zero finish early and
// raises div_zero.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : mult_div_sequencer_if.slave (start/op/a/b, hi_we/lo_we/wdata,
//           busy/done/hi/lo[/div_zero])
module mult_div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input logic                 clk,
  input logic                 reset,
  mult_div_sequencer_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic             is_div_q;
  logic             neg_q;      // negate product / quotient
  logic             neg_rem_q;  // negate remainder
  // Mult: acc_hi = running upper half, acc_lo = multiplier shifting out / low half.
  // Div:  acc_hi = partial remainder, acc_lo = dividend shifting out / quotient in.
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [WIDTH-1:0] opnd_q;     // |multiplicand| or |divisor|
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;
`ifdef MDU_DIVZERO_EN
  logic             dz_q;
  logic             div_zero_q;
`endif

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   partial;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [2*WIDTH-1:0] prod_neg;
  logic             unused_diff_bit;

  always_comb begin
    a_neg    = bus.op[0] & bus.a[WIDTH-1];
    b_neg    = bus.op[0] & bus.b[WIDTH-1];
    a_mag    = a_neg ? -bus.a : bus.a;
    b_mag    = b_neg ? -bus.b : bus.b;
    sum      = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    partial  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    // Top bit is the borrow of the trial subtract.
    diff     = {1'b0, partial} - {2'b00, opnd_q};
    ge       = ~diff[WIDTH+1];
    prod_neg = -{acc_hi_q, acc_lo_q};
  end

  // When the trial succeeds the difference is below the divisor, so bit WIDTH is zero.
  assign unused_diff_bit = diff[WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MDU_DIVZERO_EN
      dz_q       <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MDU_DIVZERO_EN
      div_zero_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            // A write in the same cycle as start is dropped.
            is_div_q  <= bus.op[1];
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            acc_hi_q  <= '0;
            acc_lo_q  <= bus.op[1] ? a_mag : b_mag;
            opnd_q    <= bus.op[1] ? b_mag : a_mag;
            cnt_q     <= CntW'(WIDTH - 1);
            busy_q    <= 1'b1;
            state_q   <= StRun;
`ifdef MDU_DIVZERO_EN
            dz_q <= 1'b0;
            if (bus.op[1] && (bus.b == '0)) begin
              // Preload the final result and let FIX pass it through untouched.
              dz_q      <= 1'b1;
              neg_q     <= 1'b0;
              neg_rem_q <= 1'b0;
              acc_hi_q  <= bus.a;
              acc_lo_q  <= '1;
              state_q   <= StFix;
            end
`endif
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        StRun: begin
          if (is_div_q) begin
            acc_hi_q <= ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], ge};
          end else begin
            acc_hi_q <= sum[WIDTH:1];
            acc_lo_q <= {sum[0], acc_lo_q[WIDTH-1:1]};
          end
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StFix: begin
          if (is_div_q) begin
            if (neg_q)     acc_lo_q <= -acc_lo_q;
            if (neg_rem_q) acc_hi_q <= -acc_hi_q;
          end else if (neg_q) begin
            {acc_hi_q, acc_lo_q} <= prod_neg;
          end
          state_q <= StDone;
        end
        StDone: begin
          // Result write overrides any MTHI/MTLO in this cycle.
          hi_q    <= acc_hi_q;
          lo_q    <= acc_lo_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
`ifdef MDU_DIVZERO_EN
          div_zero_q <= dz_q;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MDU_DIVZERO_EN
  assign bus.div_zero = div_zero_q;
`endif

endmodule

// File: tb/tb_mult_div_sequencer.sv
module tb_mult_div_sequencer;

  localparam int unsigned W = 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mult_div_sequencer_if #(.WIDTH(W)) bus ();

  mult_div_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

`ifdef MDU_DIVZERO_EN
  localparam bit DzEn = 1'b1;
`else
  localparam bit DzEn = 1'b0;
`endif

  // Reference: {hi, lo} from plain arithmetic on magnitudes plus sign rules.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic        sa, sb;
    logic [31:0] am, bm, q, r;
    logic [63:0] p;
    sa = op[0] & a[31];
    sb = op[0] & b[31];
    am = sa ? -a : a;
    bm = sb ? -b : b;
    if (!op[1]) begin
      p = {32'd0, am} * {32'd0, bm};
      if (sa ^ sb) p = -p;
      return p;
    end
    if (DzEn && b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = (bm == 32'd0) ? 32'hFFFF_FFFF : am / bm;
    r = (bm == 32'd0) ? am : am % bm;
    if (sa ^ sb) q = -q;
    if (sa) r = -r;
    return {r, q};
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    return (DzEn && op[1] && b == 32'd0) ? 2 : 34;
  endfunction

  // Called 1 time unit after an edge; returns 1 time unit after the start edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    // Scramble operands: must not affect the running operation.
    bus.op    = 2'($urandom_range(0, 3));
    bus.a     = $urandom;
    bus.b     = $urandom;
    check("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  // Waits for done; 'elapsed' edges since the start edge have already passed.
  task automatic wait_done(input string tag, input int elapsed, input logic [63:0] exp,
                           input int lat_exp, input bit dz_exp);
    int lat;
    int busy_n;
    bit seen;
    lat    = elapsed;
    busy_n = elapsed;
    seen   = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done === 1'b1) seen = 1'b1;
      else if (bus.busy === 1'b1) busy_n++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(lat_exp - 1));
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp[63:32]));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp[31:0]));
    check({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
`ifdef MDU_DIVZERO_EN
    check({tag, "_div_zero"}, 64'(bus.div_zero), 64'(dz_exp));
`else
    if (dz_exp) check({tag, "_div_zero_unexpected"}, 64'd0, 64'd1);
`endif
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int          done_cnt;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
`ifdef MDU_DIVZERO_EN
    check("reset_div_zero", 64'(bus.div_zero), 64'd0);
`endif

    // MULTU max * max
    start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 0, 64'hFFFF_FFFE_0000_0001, 34, 1'b0);

    // MULT -3*5, then DIV -7/2 started in the done cycle
    start_op(2'b01, 32'hFFFF_FFFD, 32'd5);
    wait_done("mult_neg", 0, 64'hFFFF_FFFF_FFFF_FFF1, 34, 1'b0);
    start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 0, 64'hFFFF_FFFF_FFFF_FFFD, 34, 1'b0);

    start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 0, 64'h0000_0000_8000_0000, 34, 1'b0);
    start_op(2'b10, 32'd100, 32'd7);
    wait_done("divu_100_7", 0, {32'd2, 32'd14}, 34, 1'b0);

    // MULTU 3*4 with a stray start at cycle 10 and MTHI at cycle 12
    start_op(2'b00, 32'd3, 32'd4);
    repeat (9) begin @(posedge clk); #1; end
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.a     = 32'd99;
    bus.b     = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_DEAD;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    check("busy_write_ignored", 64'(bus.hi), 64'd2);
    wait_done("multu_3_4", 12, {32'd0, 32'd12}, 34, 1'b0);

    // MTLO then MTHI in IDLE
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    check("mtlo_lo", 64'(bus.lo), 64'h1234);
    check("mtlo_hi_kept", 64'(bus.hi), 64'd0);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_CAFE;
    @(posedge clk); #1;
    bus.hi_we = 1'b0;
    check("mthi_hi", 64'(bus.hi), 64'hCAFE);
    check("mthi_lo_kept", 64'(bus.lo), 64'h1234);

    // Reset at cycle 17 of a DIVU
    start_op(2'b10, 32'd1000, 32'd3);
    repeat (16) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_lo_held", 64'(bus.lo), 64'd0);

    // Fresh MULTU 2*3; an MTLO in the start cycle is discarded
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_5555;
    start_op(2'b00, 32'd2, 32'd3);
    check("start_beats_write", 64'(bus.lo), 64'd0);
    wait_done("multu_2_3", 0, {32'd0, 32'd6}, 34, 1'b0);

    // DIVU by zero
    start_op(2'b10, 32'd7, 32'd0);
    wait_done("divu_zero", 0, {32'd7, 32'hFFFF_FFFF}, exp_lat(2'b10, 32'd0), DzEn);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(bus.done), 64'd0);

    // Random back-to-back operations against the reference model
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = $urandom_range(1, 255);
        default: b = $urandom;
      endcase
      if (i % 5 == 4) a = 32'h8000_0000;
      start_op(op, a, b);
      wait_done("random", 0, model(op, a, b), exp_lat(op, b), DzEn && op[1] && b == 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
